ram_arbiter: RTL and testbench

Arbiter and sequencer for the single shared synchronous video/CPU RAM (32K x 16, one-cycle read latency).
- Three requesters: sprite scanline renderer, tile renderer and CPU16.
- Replaces the ad-hoc combinational RAM address mux.
- Grants one requester per cycle and drives the RAM address, write data and write enable.
- Produces per-requester read-valid strobes aligned to RAM latency.
- Generates the CPU hold signal.
- Keeps starvation statistics for the CPU port.

---
 rtl/ram_arbiter_if.sv | 44 ++++
 rtl/ram_arbiter.sv | 97 +++++++++
 tb/tb_ram_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the shared-RAM arbiter and its environment
// (three requesters plus the synchronous 32K x 16 RAM).
interface ram_arbiter_if #(
  parameter int ADDR_BITS   = 15,
  parameter int DATA_BITS   = 16,
  parameter int STARVE_BITS = 8
);
  logic                   spr_req;
  logic [ADDR_BITS-1:0]   spr_addr;
  logic                   tile_req;
  logic [ADDR_BITS-1:0]   tile_addr;
  logic                   cpu_req;
  logic                   cpu_we;
  logic [ADDR_BITS-1:0]   cpu_addr;
  logic [DATA_BITS-1:0]   cpu_wdata;
  logic                   cpu_hold;
  logic [ADDR_BITS-1:0]   ram_addr;
  logic [DATA_BITS-1:0]   ram_din;
  logic                   ram_we;
  logic [DATA_BITS-1:0]   ram_dout;
  logic [DATA_BITS-1:0]   rdata;
  logic                   spr_valid;
  logic                   tile_valid;
  logic                   cpu_valid;
  logic [1:0]             grant;
  logic                   starve_flag;
  logic [STARVE_BITS-1:0] max_starve;

  // Arbiter side.
  modport master (
    input  spr_req, spr_addr, tile_req, tile_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_dout,
    output cpu_hold, ram_addr, ram_din, ram_we, rdata,
    output spr_valid, tile_valid, cpu_valid, grant, starve_flag, max_starve
  );

  // Requesters and RAM side.
  modport slave (
    output spr_req, spr_addr, tile_req, tile_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_dout,
    input  cpu_hold, ram_addr, ram_din, ram_we, rdata,
    input  spr_valid, tile_valid, cpu_valid, grant, starve_flag, max_starve
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shared video/CPU RAM arbiter: burst-locking fixed-priority grant,
// latency-aligned read-valid strobes, CPU hold and CPU starvation statistics.
module ram_arbiter #(
  parameter int ADDR_BITS    = 15,
  parameter int DATA_BITS    = 16,
  parameter int STARVE_BITS  = 8,
  parameter int STARVE_LIMIT = 64
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SPR  = 2'd1,
    OWN_TILE = 2'd2,
    OWN_CPU  = 2'd3
  } owner_e;

  localparam logic [STARVE_BITS-1:0] CNT_SAT = '1;
  localparam logic [STARVE_BITS-1:0] CNT_ONE = STARVE_BITS'(1);

  owner_e                 r_owner;
  owner_e                 w_grant;
  logic [ADDR_BITS-1:0]   r_addr_last;
  logic [ADDR_BITS-1:0]   w_addr;
  logic [2:0]             r_vld;       // {cpu, tile, spr}
  logic [STARVE_BITS-1:0] r_cnt;
  logic [STARVE_BITS-1:0] w_cnt_nxt;
  logic [STARVE_BITS-1:0] r_max;
  logic                   r_flag;
  logic                   w_cpu_hold;

  // A video owner keeps the RAM while it still requests; CPU never locks.
  always_comb begin
    w_grant = OWN_NONE;
    if (reset)                                   w_grant = OWN_NONE;
    else if (r_owner == OWN_SPR  && bus.spr_req)  w_grant = OWN_SPR;
    else if (r_owner == OWN_TILE && bus.tile_req) w_grant = OWN_TILE;
    else if (bus.spr_req)                         w_grant = OWN_SPR;
    else if (bus.tile_req)                        w_grant = OWN_TILE;
    else if (bus.cpu_req)                         w_grant = OWN_CPU;
  end

  always_comb begin
    w_addr = r_addr_last;
    unique case (w_grant)
      OWN_SPR:  w_addr = bus.spr_addr;
      OWN_TILE: w_addr = bus.tile_addr;
      OWN_CPU:  w_addr = bus.cpu_addr;
      default:  w_addr = r_addr_last;
    endcase
    if (reset) w_addr = '0;
  end

  assign w_cpu_hold = bus.cpu_req & (w_grant != OWN_CPU);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!bus.cpu_req || w_grant == OWN_CPU) w_cnt_nxt = '0;
    else if (r_cnt != CNT_SAT)              w_cnt_nxt = r_cnt + CNT_ONE;
  end

  // Flag and peak track the post-update count so they agree with the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= OWN_NONE;
      r_addr_last <= '0;
      r_vld       <= '0;
      r_cnt       <= '0;
      r_max       <= '0;
      r_flag      <= 1'b0;
    end else begin
      r_owner     <= w_grant;
      r_addr_last <= w_addr;
      r_vld       <= {w_grant == OWN_CPU, w_grant == OWN_TILE, w_grant == OWN_SPR};
      r_cnt       <= w_cnt_nxt;
      r_flag      <= (32'(w_cnt_nxt) >= STARVE_LIMIT);
      if (w_cnt_nxt > r_max) r_max <= w_cnt_nxt;
    end
  end

  // Reset masks the registered outputs in the very cycle it is sampled.
  assign bus.grant       = w_grant;
  assign bus.cpu_hold    = w_cpu_hold;
  assign bus.ram_addr    = w_addr;
  assign bus.ram_din     = bus.cpu_wdata;
  assign bus.ram_we      = (w_grant == OWN_CPU) & bus.cpu_we;
  assign bus.rdata       = bus.ram_dout;
  assign bus.spr_valid   = r_vld[0] & ~reset;
  assign bus.tile_valid  = r_vld[1] & ~reset;
  assign bus.cpu_valid   = r_vld[2] & ~reset;
  assign bus.starve_flag = r_flag & ~reset;
  assign bus.max_starve  = reset ? '0 : r_max;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_ram_arbiter;
  localparam int AB = 15;
  localparam int DB = 16;
  localparam int SB = 8;
  localparam int SL = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .STARVE_BITS(SB)) bus ();
  ram_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .STARVE_BITS(SB), .STARVE_LIMIT(SL))
    dut (.clk(clk), .reset(rst), .bus(bus));

  // RAM model: contents default to a pattern until first written.
  logic [DB-1:0] mem   [0:(1<<AB)-1];
  bit            mem_w [0:(1<<AB)-1];
  logic [DB-1:0] smem  [0:(1<<AB)-1];
  bit            smem_w[0:(1<<AB)-1];

  function automatic logic [DB-1:0] init_val(input logic [AB-1:0] a);
    return (a == 15'h0123) ? 16'hBEEF : (16'(a) ^ 16'h5A5A);
  endfunction

  always @(posedge clk) begin
    bus.ram_dout <= mem_w[bus.ram_addr] ? mem[bus.ram_addr] : init_val(bus.ram_addr);
    if (bus.ram_we) begin
      mem[bus.ram_addr]   <= bus.ram_din;
      mem_w[bus.ram_addr] <= 1'b1;
    end
  end

  typedef struct {
    logic          rst, sr, tr, cr, we;
    logic [AB-1:0] sa, ta, ca;
    logic [DB-1:0] wd;
    logic [1:0]    eg;
    logic          eh, ewe;
    logic [AB-1:0] ea;
    logic [2:0]    ev;   // {cpu, tile, spr}
    logic          crd;
    logic [DB-1:0] erd;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // Behavioural reference state.
  int            m_own, m_vld, m_cnt, m_max;
  logic [AB-1:0] m_last;
  logic [DB-1:0] m_rd;
  bit            m_hold_prev;

  task automatic model_check(input vec_t v);
    int            g;
    bit            r[4];
    logic [AB-1:0] ea;
    bit            eh, ewe;
    r[0] = 1'b0; r[1] = v.sr; r[2] = v.tr; r[3] = v.cr;
    if (v.rst) begin
      chk("rst grant", bus.grant, 0);
      chk("rst hold", bus.cpu_hold, v.cr);
      chk("rst we", bus.ram_we, 0);
      chk("rst addr", bus.ram_addr, 0);
      chk("rst valids", {bus.cpu_valid, bus.tile_valid, bus.spr_valid}, 0);
      chk("rst flag", bus.starve_flag, 0);
      chk("rst max", bus.max_starve, 0);
      m_own = 0; m_vld = 0; m_cnt = 0; m_max = 0; m_last = '0; m_hold_prev = v.cr;
    end else begin
      g = 0;
      if ((m_own == 1 || m_own == 2) && r[m_own]) g = m_own;
      else for (int k = 1; k <= 3; k++) if (r[k] && g == 0) g = k;
      ea  = (g == 1) ? v.sa : (g == 2) ? v.ta : (g == 3) ? v.ca : m_last;
      eh  = v.cr && g != 3;
      ewe = (g == 3) && v.we;
      chk("grant", bus.grant, g);
      chk("cpu_hold", bus.cpu_hold, eh);
      chk("ram_we", bus.ram_we, ewe);
      chk("ram_addr", bus.ram_addr, ea);
      chk("ram_din", bus.ram_din, v.wd);
      chk("spr_valid", bus.spr_valid, m_vld == 1);
      chk("tile_valid", bus.tile_valid, m_vld == 2);
      chk("cpu_valid", bus.cpu_valid, m_vld == 3);
      if (m_vld != 0) chk("rdata", bus.rdata, m_rd);
      chk("starve_flag", bus.starve_flag, m_cnt >= SL);
      chk("max_starve", bus.max_starve, m_max);
      m_vld = g; m_own = g; m_last = ea; m_hold_prev = eh;
      if (g != 0) m_rd = smem_w[ea] ? smem[ea] : init_val(ea);
      if (ewe) begin smem[ea] = v.wd; smem_w[ea] = 1'b1; end
      if (!v.cr || g == 3) m_cnt = 0;
      else if (m_cnt < 255) m_cnt = m_cnt + 1;
      if (m_cnt > m_max) m_max = m_cnt;
    end
  endtask

  task automatic tick(input vec_t v);
    @(posedge clk); #1;
    rst = v.rst;
    bus.spr_req = v.sr; bus.spr_addr = v.sa;
    bus.tile_req = v.tr; bus.tile_addr = v.ta;
    bus.cpu_req = v.cr; bus.cpu_we = v.we; bus.cpu_addr = v.ca; bus.cpu_wdata = v.wd;
    @(negedge clk);
    model_check(v);
  endtask

  function automatic vec_t row(input logic [3:0] rq, input logic [15:0] sa, ta, ca, wd,
                               input logic [1:0] eg, input logic eh, ewe,
                               input logic [15:0] ea, input logic [2:0] ev,
                               input logic crd, input logic [15:0] erd);
    vec_t v;
    v.rst = 1'b0; {v.sr, v.tr, v.cr, v.we} = rq;
    v.sa = sa[AB-1:0]; v.ta = ta[AB-1:0]; v.ca = ca[AB-1:0]; v.wd = wd;
    v.eg = eg; v.eh = eh; v.ewe = ewe; v.ea = ea[AB-1:0]; v.ev = ev;
    v.crd = crd; v.erd = erd;
    return v;
  endfunction

  function automatic vec_t simple(input logic rs, sr, tr, cr, we,
                                  input logic [15:0] ca, wd);
    vec_t v;
    v = row({sr, tr, cr, we}, 16'h1000, 16'h2000, ca, wd,
            2'd0, 1'b0, 1'b0, 16'h0, 3'b000, 1'b0, 16'h0);
    v.rst = rs;
    return v;
  endfunction

  vec_t tbl[17];
  vec_t v;
  logic sr_r, tr_r, lwe;
  logic [AB-1:0] lca;
  logic [DB-1:0] lwd;

  initial begin
    //                 sr tr cr we   sa       ta       ca       wd       eg    eh    ewe   ea        ev      crd   erd
    tbl[0]  = row(4'b0010, 16'h1000, 16'h2000, 16'h0123, 16'h0000, 2'd3, 1'b0, 1'b0, 16'h0123, 3'b000, 1'b0, 16'h0);
    tbl[1]  = row(4'b0000, 16'h1000, 16'h2000, 16'h0123, 16'h0000, 2'd0, 1'b0, 1'b0, 16'h0123, 3'b100, 1'b1, 16'hBEEF);
    tbl[2]  = row(4'b1110, 16'h1000, 16'h2000, 16'h0456, 16'h0000, 2'd1, 1'b1, 1'b0, 16'h1000, 3'b000, 1'b0, 16'h0);
    tbl[3]  = row(4'b1110, 16'h1000, 16'h2000, 16'h0456, 16'h0000, 2'd1, 1'b1, 1'b0, 16'h1000, 3'b001, 1'b0, 16'h0);
    tbl[4]  = row(4'b0110, 16'h1000, 16'h2000, 16'h0456, 16'h0000, 2'd2, 1'b1, 1'b0, 16'h2000, 3'b001, 1'b0, 16'h0);
    tbl[5]  = row(4'b0010, 16'h1000, 16'h2000, 16'h0456, 16'h0000, 2'd3, 1'b0, 1'b0, 16'h0456, 3'b010, 1'b0, 16'h0);
    tbl[6]  = row(4'b0000, 16'h1000, 16'h2000, 16'h0456, 16'h0000, 2'd0, 1'b0, 1'b0, 16'h0456, 3'b100, 1'b0, 16'h0);
    tbl[7]  = row(4'b0100, 16'h1000, 16'h6000, 16'h0456, 16'h0000, 2'd2, 1'b0, 1'b0, 16'h6000, 3'b000, 1'b0, 16'h0);
    tbl[8]  = row(4'b1100, 16'h1000, 16'h6001, 16'h0456, 16'h0000, 2'd2, 1'b0, 1'b0, 16'h6001, 3'b010, 1'b0, 16'h0);
    tbl[9]  = row(4'b1100, 16'h1000, 16'h6002, 16'h0456, 16'h0000, 2'd2, 1'b0, 1'b0, 16'h6002, 3'b010, 1'b0, 16'h0);
    tbl[10] = row(4'b1100, 16'h1000, 16'h6003, 16'h0456, 16'h0000, 2'd2, 1'b0, 1'b0, 16'h6003, 3'b010, 1'b0, 16'h0);
    tbl[11] = row(4'b1000, 16'h1000, 16'h6003, 16'h0456, 16'h0000, 2'd1, 1'b0, 1'b0, 16'h1000, 3'b010, 1'b0, 16'h0);
    tbl[12] = row(4'b0000, 16'h1000, 16'h6003, 16'h0456, 16'h0000, 2'd0, 1'b0, 1'b0, 16'h1000, 3'b001, 1'b0, 16'h0);
    tbl[13] = row(4'b0011, 16'h1000, 16'h6003, 16'h7F00, 16'h0101, 2'd3, 1'b0, 1'b1, 16'h7F00, 3'b000, 1'b0, 16'h0);
    tbl[14] = row(4'b0000, 16'h1000, 16'h6003, 16'h7F00, 16'h0101, 2'd0, 1'b0, 1'b0, 16'h7F00, 3'b100, 1'b0, 16'h0);
    tbl[15] = row(4'b0010, 16'h1000, 16'h6003, 16'h7F00, 16'h0101, 2'd3, 1'b0, 1'b0, 16'h7F00, 3'b000, 1'b0, 16'h0);
    tbl[16] = row(4'b0000, 16'h1000, 16'h6003, 16'h7F00, 16'h0101, 2'd0, 1'b0, 1'b0, 16'h7F00, 3'b100, 1'b1, 16'h0101);

    m_own = 0; m_vld = 0; m_cnt = 0; m_max = 0; m_last = '0; m_rd = '0; m_hold_prev = 1'b0;

    // Reset with all requesters asserting: they must be ignored.
    tick(simple(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0));
    tick(simple(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0));

    for (int k = 0; k < 17; k++) begin
      tick(tbl[k]);
      chk($sformatf("row%0d grant", k), bus.grant, tbl[k].eg);
      chk($sformatf("row%0d hold", k), bus.cpu_hold, tbl[k].eh);
      chk($sformatf("row%0d we", k), bus.ram_we, tbl[k].ewe);
      chk($sformatf("row%0d addr", k), bus.ram_addr, tbl[k].ea);
      chk($sformatf("row%0d valids", k), {bus.cpu_valid, bus.tile_valid, bus.spr_valid}, tbl[k].ev);
      if (tbl[k].crd) chk($sformatf("row%0d rdata", k), bus.rdata, tbl[k].erd);
    end

    // Tile holds the RAM for 70 cycles while the CPU waits.
    for (int c = 1; c <= 70; c++) begin
      tick(simple(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0));
      if (c == 64) chk("starve flag before limit", bus.starve_flag, 0);
      if (c == 65) chk("starve flag at limit", bus.starve_flag, 1);
    end
    tick(simple(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0));
    chk("starve cpu grant", bus.grant, 3);
    chk("starve max 70", bus.max_starve, 70);
    chk("starve flag still set", bus.starve_flag, 1);
    tick(simple(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0));
    chk("starve flag cleared", bus.starve_flag, 0);
    chk("starve max kept", bus.max_starve, 70);

    // Saturation of the starvation counter.
    for (int c = 0; c < 300; c++) tick(simple(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h0));
    tick(simple(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0300, 16'h0));
    chk("sat max", bus.max_starve, 255);

    // Reset lands on a CPU write grant.
    tick(simple(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7F10, 16'hAAAA));
    tick(simple(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7F10, 16'hAAAA));
    chk("rstw grant", bus.grant, 0);
    chk("rstw we", bus.ram_we, 0);
    chk("rstw cpu_valid", bus.cpu_valid, 0);
    chk("rstw max", bus.max_starve, 0);
    chk("rstw hold", bus.cpu_hold, 1);
    tick(simple(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7F10, 16'hAAAA));
    chk("post rst grant", bus.grant, 3);
    chk("post rst we", bus.ram_we, 1);
    tick(simple(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7F10, 16'h0));
    chk("post rst cpu_valid", bus.cpu_valid, 1);

    // Randomized traffic; a held CPU keeps its request stable.
    sr_r = 1'b0; tr_r = 1'b0; lwe = 1'b0; lca = '0; lwd = '0;
    for (int n = 0; n < 3000; n++) begin
      v = simple(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      v.rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) sr_r = ~sr_r;
      if ($urandom_range(0, 3) == 0) tr_r = ~tr_r;
      v.sr = sr_r; v.tr = tr_r;
      v.sa = AB'($urandom); v.ta = AB'($urandom);
      if (m_hold_prev) begin
        v.cr = 1'b1; v.we = lwe; v.ca = lca; v.wd = lwd;
      end else begin
        v.cr = ($urandom_range(0, 2) != 0);
        v.we = 1'($urandom_range(0, 1));
        v.ca = ($urandom_range(0, 1) != 0) ? AB'($urandom_range(0, 15)) : AB'($urandom);
        v.wd = DB'($urandom);
      end
      lwe = v.we; lca = v.ca; lwd = v.wd;
      tick(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
